// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      ACTIVE   = 2'd1,
      FLUSH    = 2'd2
   } rx_ctrl_state_e;

   localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received bytes. The head is read combinationally.
// Flush empties the FIFO and overrides push and pop in the same cycle.
module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      cnt;
   logic             do_push, do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign level   = cnt;
   assign dout    = mem[rd_ptr];
   // Guard against misuse: never write past a full FIFO or read an empty one.
   assign do_push = push && !flush && (!full || pop);
   assign do_pop  = pop && !flush && !empty;

   // Storage array. It is not reset because occupancy tracks which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy update. DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Controller for the uart_rx receiver. It contains the sampling divider, the CRC-mode
// latch, the receive FIFO, error and timeout tracking, and interrupt aggregation.
module uart_rx_ctrl import uart_rx_pkg::*; #(
   parameter int DIV_W      = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int TO_TRIGS   = 160
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          cfg_en_i,
   input  logic [DIV_W-1:0]              cfg_div_i,
   input  logic                          cfg_crc_en_i,
   input  logic                          clear_i,
   output logic                          trigger_o,
   output logic                          crc_en_o,
   input  logic [7:0]                    rx_data_i,
   input  logic                          rx_int_i,
   input  logic                          err_int_i,
   output logic                          m_valid_o,
   output logic [7:0]                    m_data_o,
   input  logic                          m_ready_i,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          overflow_o,
   output logic [ERR_CNT_W-1:0]          err_cnt_o,
   output logic                          irq_o
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = $clog2(TO_TRIGS + 1);

   rx_ctrl_state_e       state, state_n;
   logic [DIV_W-1:0]     div_cnt, div_max;
   logic                 trig_q, crc_q, ovf_q, to_flag, irq_q;
   logic [ERR_CNT_W-1:0] err_q;
   logic [TW-1:0]        to_cnt;
   logic [LW-1:0]        level;
   logic                 active, do_clear, run, push, pop, full, empty;

   assign active    = (state == ACTIVE);
   // A clear takes effect at once: in the clear_i cycle itself, and again during FLUSH.
   assign do_clear  = clear_i || (state == FLUSH);
   // The divider runs only while the FSM stays ACTIVE. This stops a stale pulse from
   // leaking into the first cycle after leaving ACTIVE.
   assign run       = active && (state_n == ACTIVE);
   assign div_max   = (cfg_div_i == '0) ? DIV_W'(1) : cfg_div_i;
   assign pop       = m_valid_o && m_ready_i;
   assign push      = active && rx_int_i && !clear_i && (!full || pop);

   assign trigger_o  = trig_q;
   assign crc_en_o   = crc_q;
   assign m_valid_o  = !empty;
   assign level_o    = level;
   assign overflow_o = ovf_q;
   assign err_cnt_o  = err_q;
   assign irq_o      = irq_q;

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= DISABLED;
      else       state <= state_n;
   end

   // Next-state logic. In ACTIVE, clear wins over disable so a clear request is never lost.
   always_comb begin
      state_n = state;
      unique case (state)
         DISABLED: if (!clear_i && cfg_en_i) state_n = ACTIVE;
         ACTIVE: begin
            if (clear_i)        state_n = FLUSH;
            else if (!cfg_en_i) state_n = DISABLED;
         end
         FLUSH:    state_n = cfg_en_i ? ACTIVE : DISABLED;
         default:  state_n = DISABLED;
      endcase
   end

   // Sampling divider. It wraps silently if the period shrinks below the current count.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_cnt <= '0;
         trig_q  <= 1'b0;
      end else if (!run) begin
         div_cnt <= '0;
         trig_q  <= 1'b0;
      end else if (div_cnt == div_max - 1'b1) begin
         div_cnt <= '0;
         trig_q  <= 1'b1;
      end else if (div_cnt >= div_max) begin
         div_cnt <= '0;
         trig_q  <= 1'b0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
         trig_q  <= 1'b0;
      end
   end

   // CRC mode tracks the request only while disabled, so it stays frozen for a whole session.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                 crc_q <= 1'b0;
      else if (state == DISABLED) crc_q <= cfg_crc_en_i;
   end

   // Sticky overflow flag and saturating error counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ovf_q <= 1'b0;
         err_q <= '0;
      end else if (do_clear) begin
         ovf_q <= 1'b0;
         err_q <= '0;
      end else begin
         if (active && rx_int_i && full && !pop) ovf_q <= 1'b1;
         if (active && err_int_i && (err_q != '1)) err_q <= err_q + 1'b1;
      end
   end

   // Receive-idle timeout. It counts triggers while bytes sit unread and no new byte arrives.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         to_cnt  <= '0;
         to_flag <= 1'b0;
      end else if (do_clear || empty || push) begin
         to_cnt <= '0;
         if (do_clear || empty) to_flag <= 1'b0;
      end else if (trig_q && (to_cnt != TW'(TO_TRIGS))) begin
         to_cnt <= to_cnt + 1'b1;
         if (to_cnt == TW'(TO_TRIGS - 1)) to_flag <= 1'b1;
      end
   end

   // Registered interrupt built from the already-registered status.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) irq_q <= 1'b0;
      else       irq_q <= (level >= LW'(FIFO_DEPTH / 2)) | to_flag | ovf_q | (err_q != '0);
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .flush (do_clear),
      .push  (push),
      .din   (rx_data_i),
      .pop   (pop),
      .dout  (m_data_o),
      .full  (full),
      .empty (empty),
      .level (level)
   );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed scenarios, then a randomized stream
// compared against a queue-based reference model.
module tb_uart_rx_ctrl;

   localparam int DIV_W = 16;
   localparam int DEPTH = 8;
   localparam int TO    = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_en, cfg_crc_en, clear, rx_int, err_int, m_ready;
   logic [DIV_W-1:0] cfg_div;
   logic [7:0]       rx_data;
   logic             trigger, crc_en, m_valid, overflow, irq;
   logic [7:0]       m_data, err_cnt;
   logic [3:0]       level;

   int n_chk  = 0;
   int n_fail = 0;

   uart_rx_ctrl #(.DIV_W(DIV_W), .FIFO_DEPTH(DEPTH), .TO_TRIGS(TO)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cfg_en_i     (cfg_en),
      .cfg_div_i    (cfg_div),
      .cfg_crc_en_i (cfg_crc_en),
      .clear_i      (clear),
      .trigger_o    (trigger),
      .crc_en_o     (crc_en),
      .rx_data_i    (rx_data),
      .rx_int_i     (rx_int),
      .err_int_i    (err_int),
      .m_valid_o    (m_valid),
      .m_data_o     (m_data),
      .m_ready_i    (m_ready),
      .level_o      (level),
      .overflow_o   (overflow),
      .err_cnt_o    (err_cnt),
      .irq_o        (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      rx_data = b;
      rx_int  = 1'b1;
      step();
      rx_int  = 1'b0;
   endtask

   initial begin
      logic [7:0] exp3 [3];
      logic [7:0] q [$];
      int ntrig, guard, ovf_m, err_m, p_lvl, p_ovf, p_err;
      bit flush_next, rx_r, rdy_r, err_r, clr_r, pop_m, full_m;
      logic [7:0] d_r;

      rst = 1'b1; cfg_en = 0; cfg_crc_en = 0; clear = 0; rx_int = 0; err_int = 0;
      m_ready = 0; cfg_div = '0; rx_data = '0;
      #12;
      chk("rst_trigger", trigger, 0);
      chk("rst_crc", crc_en, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_err", err_cnt, 0);
      chk("rst_irq", irq, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      step();

      // Divider with period 4: one-cycle pulses at 4, 8 and 12 edges after entering ACTIVE.
      cfg_div = 16'd4;
      cfg_en  = 1'b1;
      step();
      for (int i = 1; i <= 12; i++) begin
         step();
         chk("div4_trigger", trigger, (i % 4) == 0);
      end
      cfg_div = 16'd0;
      step(); step();
      for (int i = 0; i < 5; i++) begin
         chk("div0_trigger", trigger, 1);
         step();
      end

      // CRC mode is latched while disabled and frozen while active.
      cfg_en = 1'b0; cfg_crc_en = 1'b1;
      step(); step(); step();
      chk("crc_disabled", crc_en, 1);
      chk("trig_disabled", trigger, 0);
      cfg_en = 1'b1;
      step();
      cfg_crc_en = 1'b0;
      step(); step(); step();
      chk("crc_frozen", crc_en, 1);
      cfg_en = 1'b0;
      step(); step();
      chk("crc_after_dis", crc_en, 0);

      // FIFO ordering.
      cfg_div = 16'd1000; cfg_en = 1'b1;
      step();
      exp3 = '{8'hA5, 8'h3C, 8'hFF};
      for (int i = 0; i < 3; i++) push_byte(exp3[i]);
      chk("fifo_level3", level, 3);
      chk("fifo_valid", m_valid, 1);
      chk("fifo_head", m_data, 8'hA5);
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("fifo_order", m_data, exp3[i]);
         chk("fifo_order_vld", m_valid, 1);
         step();
      end
      m_ready = 1'b0;
      chk("fifo_drained", m_valid, 0);
      chk("fifo_lvl0", level, 0);

      // Overflow at full, then push and pop together at full.
      for (int i = 0; i < 9; i++) push_byte(8'h10 + 8'(i));
      chk("ovf_level", level, DEPTH);
      chk("ovf_flag", overflow, 1);
      chk("ovf_head", m_data, 8'h10);
      step();
      chk("ovf_irq", irq, 1);
      rx_data = 8'h77; rx_int = 1'b1; m_ready = 1'b1;
      step();
      rx_int = 1'b0; m_ready = 1'b0;
      chk("pushpop_level", level, DEPTH);
      chk("pushpop_ovf", overflow, 1);
      chk("pushpop_head", m_data, 8'h11);

      // Error counter saturation, then clear.
      err_int = 1'b1;
      repeat (300) step();
      err_int = 1'b0;
      chk("err_sat", err_cnt, 255);
      clear = 1'b1;
      step();
      clear = 1'b0;
      chk("clr_err", err_cnt, 0);
      chk("clr_ovf", overflow, 0);
      chk("clr_level", level, 0);
      step();
      chk("clr_irq", irq, 0);

      // Idle timeout after TO triggers with one byte waiting.
      cfg_div = 16'd2;
      push_byte(8'h5A);
      ntrig = 0; guard = 0;
      while (ntrig < TO && guard < 60) begin
         if (trigger) ntrig++;
         if (ntrig < TO) begin
            step();
            guard++;
         end
      end
      chk("to_trig_seen", ntrig, TO);
      chk("to_irq_early", irq, 0);
      step(); step();
      chk("to_irq", irq, 1);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      step(); step();
      chk("to_irq_clr", irq, 0);

      // Randomized stream against the queue model. A long divider period keeps the timeout quiet.
      cfg_div = 16'd50000;
      clear = 1'b1; step(); clear = 1'b0; step();
      q.delete();
      ovf_m = 0; err_m = 0; p_lvl = 0; p_ovf = 0; p_err = 0; flush_next = 0;
      for (int it = 0; it < 2000; it++) begin
         chk("rnd_valid", m_valid, q.size() != 0);
         if (q.size() != 0) chk("rnd_data", m_data, q[0]);
         chk("rnd_level", level, q.size());
         chk("rnd_ovf", overflow, ovf_m);
         chk("rnd_err", err_cnt, err_m);
         chk("rnd_irq", irq, (p_lvl >= DEPTH / 2) || (p_ovf != 0) || (p_err != 0));
         p_lvl = q.size(); p_ovf = ovf_m; p_err = err_m;

         rx_r  = $urandom_range(0, 1) == 1;
         rdy_r = $urandom_range(0, 2) == 0;
         err_r = $urandom_range(0, 15) == 0;
         clr_r = ($urandom_range(0, 199) == 0) && !flush_next;
         d_r   = 8'($urandom);
         rx_int = rx_r; m_ready = rdy_r; err_int = err_r; clear = clr_r; rx_data = d_r;

         if (clr_r) begin
            q.delete(); ovf_m = 0; err_m = 0; flush_next = 1;
         end else if (flush_next) begin
            flush_next = 0;
         end else begin
            full_m = q.size() == DEPTH;
            pop_m  = (q.size() != 0) && rdy_r;
            if (pop_m) void'(q.pop_front());
            if (rx_r) begin
               if (full_m && !pop_m) ovf_m = 1;
               else q.push_back(d_r);
            end
            if (err_r && err_m < 255) err_m++;
         end
         step();
      end
      rx_int = 0; m_ready = 0; err_int = 0; clear = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that sequences the UART receiver (uart_rx).
- Generates the receiver's sampling trigger from a programmable divider.
- Owns and latches the receiver's CRC-enable configuration.
- Collects received bytes into a small FIFO drained over a valid/ready stream.
- Aggregates error status and a receive-idle timeout into the peripheral's interrupt outputs.

Parameters:
DIV_W, 16, width of trigger divider and cfg_div_i
FIFO_DEPTH, 8, receive FIFO entries (power of two, >=2)
TO_TRIGS, 160, trigger pulses with no new byte before timeout (>=1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
cfg_en_i  in  1  receiver enable
cfg_div_i  in  DIV_W  trigger period in clk cycles; 0 treated as 1
cfg_crc_en_i  in  1  requested CRC mode
clear_i  in  1  single-cycle pulse: flush FIFO, clear sticky flags and counter
trigger_o  out  1  sampling pulse to uart_rx.trigger_i
crc_en_o  out  1  to uart_rx.crc_en_i
rx_data_i  in  8  from uart_rx.data_o
rx_int_i  in  1  from uart_rx.rx_int_o (byte-complete pulse)
err_int_i  in  1  from uart_rx.err_int_o (parity/CRC/stop error pulse)
m_valid_o  out  1  FIFO head valid
m_data_o  out  8  FIFO head byte
m_ready_i  in  1  consumer accepts head
level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow_o  out  1  sticky: byte dropped because FIFO full
err_cnt_o  out  8  saturating error count
irq_o  out  1  level interrupt

Behaviour:
- Reset: all outputs 0; state DISABLED; FIFO empty; divider count 0.
- Clocking: single clock domain, all flops on clk_i, async clear on rst_i.
- FSM has three states:
  - DISABLED: trigger_o held 0; crc_en_o <= cfg_crc_en_i every cycle; divider count held 0. cfg_en_i=1 -> ACTIVE.
  - ACTIVE: divider runs; crc_en_o frozen (CRC mode changes while active are ignored until next disable). cfg_en_i=0 -> DISABLED. clear_i -> FLUSH.
  - FLUSH: one cycle; FIFO pointers, overflow_o, err_cnt_o and timeout counter zeroed; trigger_o=0; divider count reset. Next state is ACTIVE if cfg_en_i, else DISABLED.
  - clear_i in DISABLED performs the same clears in that cycle and stays DISABLED.
- Divider:
  - Counter counts 0..max(cfg_div_i,1)-1.
  - trigger_o=1 for exactly one cycle when count==max-1, then count wraps to 0.
  - First pulse comes max cycles after entering ACTIVE. cfg_div_i=1 or 0 gives a pulse every cycle.
  - If cfg_div_i changes to a value <= current count: wrap to 0 next cycle, no pulse that cycle.
  - trigger_o is registered.
- FIFO write: rx_int_i=1 in ACTIVE pushes rx_data_i.
  - If full and no pop in the same cycle: byte dropped, overflow_o set.
  - Simultaneous push and pop when full: both occur, no overflow.
  - rx_int_i outside ACTIVE is ignored.
- FIFO read: pop when m_valid_o && m_ready_i.
  - m_data_o is the head, stable while m_valid_o && !m_ready_i.
  - First-word latency: byte visible on m_valid_o the cycle after push.
  - level_o is updated in the same cycle as pointers.
- Errors: err_int_i=1 in ACTIVE increments err_cnt_o, saturating at 255.
  - rx_int_i and err_int_i together in one cycle: byte pushed and counter incremented.
- Timeout counter:
  - Reset to 0 on push or when FIFO empty.
  - Increments on each trigger_o while FIFO non-empty and no push occurs.
  - At TO_TRIGS, sets sticky timeout flag and holds.
  - Timeout flag cleared by clear_i or when FIFO becomes empty.
- irq_o = (level_o >= FIFO_DEPTH/2) | timeout flag | overflow_o | (err_cnt_o != 0). Registered, one-cycle latency.
- Reset mid-frame: immediate async clear; uart_rx is reset by the same rst_i.
- Disable mid-frame: FIFO contents retained and still drainable; partial frame inside uart_rx is abandoned as no further triggers arrive.

Decomposition:
- Package uart_rx_pkg:
  - enum rx_ctrl_state_e {DISABLED, ACTIVE, FLUSH}
  - localparam ERR_CNT_W=8
- Sub-module uart_rx_fifo (synchronous, parameterised depth/width, push/pop/full/empty/level) instantiated once.
- Divider, FSM and timeout logic stay in uart_rx_ctrl.

Test Plan:
- cfg_div_i=4, cfg_en_i 0->1 -> trigger_o pulses at cycles 4, 8, 12 after enable, each one cycle wide; cfg_div_i=0 -> pulse every cycle.
- cfg_crc_en_i=1 while DISABLED, enable, then set cfg_crc_en_i=0 -> crc_en_o stays 1 until cfg_en_i drops, then 0 next cycle.
- Push 0xA5, 0x3C, 0xFF with m_ready_i=0 -> level_o=3, m_data_o=0xA5; assert m_ready_i -> bytes out in order over 3 cycles, m_valid_o low after.
- DEPTH=8: push 9 bytes with no pop -> 9th dropped, overflow_o=1, irq_o=1; push+pop same cycle at full -> level_o stays 8, overflow_o unchanged.
- 300 err_int_i pulses -> err_cnt_o=255; clear_i -> next cycle err_cnt_o=0, overflow_o=0, level_o=0, irq_o=0 one cycle later.
- One byte pushed, TO_TRIGS=3, cfg_div_i=2, no further rx_int_i -> irq_o=1 after 3rd trigger_o; pop byte -> timeout flag and irq_o clear.
